// File: rtl/pipo_wr_arbiter.sv
// Round-robin write arbiter for a shared parallel-in/parallel-out register.
// One requester is granted at a time. Its word is captured into dout_o, and
// load_o/ack_o pulse for one cycle. A fixed idle gap then follows each load.
module pipo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*WIDTH-1:0]     din_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           ack_o,
  output logic                      load_o,
  output logic [WIDTH-1:0]          dout_o,
  output logic [$clog2(NREQ)-1:0]   owner_o,
  output logic                      busy_o
);

  localparam int IW = $clog2(NREQ);
  // The counter is preloaded with GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic [NREQ-1:0]     ack_q;
  logic                load_q;
  logic [WIDTH-1:0]    dout_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       win_q;
  logic [IW-1:0]       ptr_q;
  logic [3:0]          gap_cnt_q;

  logic [WIDTH-1:0]    din_arr [NREQ];
  logic [IW-1:0]       scan_idx [NREQ];
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic                take_load;
  logic [IW-1:0]       ptr_inc;

  // Split the flattened data bus into one word per requester.
  // scan_idx[k] is the requester examined k-th when scanning upward from the pointer.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign din_arr[gi] = din_i[gi*WIDTH +: WIDTH];

      // Wrap the scan position (ptr + gi) back into 0..NREQ-1.
      always_comb begin
        int s;
        s = int'(ptr_q) + gi;
        if (s >= NREQ) begin
          s = s - NREQ;
        end
        scan_idx[gi] = IW'(s);
      end
    end
  endgenerate

  // Find the first active request at or after the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req_i[scan_idx[k]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[k];
      end
    end
  end

  // The load goes ahead only if the granted requester still holds its request in GRANT.
  assign take_load = (state_q == S_GRANT) && req_i[win_q];
  assign ptr_inc   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

  // Arbitration FSM. gnt, ack, load, owner and the pointer are all registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      load_q    <= 1'b0;
      owner_q   <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      load_q <= 1'b0;
      ack_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            win_q   <= pick_idx;
            gnt_q   <= ONE_HOT0 << pick_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req_i[win_q]) begin
            load_q  <= 1'b1;
            ack_q   <= gnt_q;
            owner_q <= win_q;
            state_q <= S_ACK;
          end else begin
            // The requester withdrew, so abort and leave the pointer untouched.
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_ACK: begin
          gnt_q <= '0;
          ptr_q <= ptr_inc;
          if (GAP_CYCLES == 0) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= GAP_LOAD;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Shared holding register. A clear takes priority over a coincident load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
    end else if (clr_i) begin
      dout_q <= '0;
    end else if (take_load) begin
      dout_q <= din_arr[win_q];
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign load_o  = load_q;
  assign dout_o  = dout_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pipo_wr_arbiter.sv
// Self-checking bench for pipo_wr_arbiter.
// The reference model tracks each transaction as a timeline measured from its grant edge.
module tb_pipo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int GAP   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clr = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] din = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  load;
  logic [WIDTH-1:0]      dout;
  logic [1:0]            owner;
  logic                  busy;

  pipo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .req_i(req), .din_i(din),
    .gnt_o(gnt), .ack_o(ack), .load_o(load), .dout_o(dout),
    .owner_o(owner), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         cyc = 0;
  bit         m_active, m_loaded;
  int         m_g, m_w, m_ptr, m_owner;
  logic [3:0] m_dout;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_loaded = 0; m_ptr = 0; m_owner = 0; m_dout = '0;
  endfunction

  // Advance the model by one rising edge, using the inputs present at that edge.
  function automatic void model_edge();
    int o;
    cyc++;
    if (m_active) begin
      o = cyc - m_g;
      if (o == 1) begin
        if (req[m_w]) begin
          m_loaded = 1; m_dout = din[m_w*WIDTH +: WIDTH]; m_owner = m_w;
        end else begin
          m_active = 0;
        end
      end else if (m_loaded && o == 2) begin
        m_ptr = (m_w + 1) % NREQ;
      end
      if (m_active && m_loaded && o == 2 + GAP) m_active = 0;
    end else if (req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!m_active && req[idx]) begin
          m_active = 1; m_loaded = 0; m_g = cyc; m_w = idx;
        end
      end
    end
    if (clr) m_dout = '0;
  endfunction

  // Run one clock edge, then compare every output with the model away from that edge.
  task automatic step();
    int o;
    logic [3:0] e_gnt, e_ack;
    logic e_load;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    o = cyc - m_g;
    e_gnt  = (m_active && o <= 1) ? 4'(1 << m_w) : 4'h0;
    e_ack  = (m_active && o == 1) ? 4'(1 << m_w) : 4'h0;
    e_load = m_active && (o == 1);
    check_val("gnt",   gnt,   e_gnt);
    check_val("ack",   ack,   e_ack);
    check_val("load",  load,  e_load);
    check_val("dout",  dout,  m_dout);
    check_val("owner", owner, m_owner);
    check_val("busy",  busy,  m_active);
    if (load) $display("txn: cyc=%0d owner=%0d dout=%h ack=%b", cyc, owner, dout, ack);
  endtask

  // Assert reset between clock edges and confirm that the outputs clear without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_gnt",   gnt,   0);
    check_val("rst_ack",   ack,   0);
    check_val("rst_load",  load,  0);
    check_val("rst_dout",  dout,  0);
    check_val("rst_owner", owner, 0);
    check_val("rst_busy",  busy,  0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    req = '0; clr = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (m_active && n < 20);
    check_val("idle_timeout", busy, 0);
  endtask

  logic [3:0] seq_dout [5];
  int         seq_cyc [5];
  int         nload;

  initial begin
    model_reset();
    // Hold reset across a few edges, then release it between edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("por_busy", busy, 0);
    check_val("por_dout", dout, 0);
    rst_n = 1'b1;

    // Reset arrives while requester 1 is in GRANT. Afterwards, requester 1 is granted again from pointer 0.
    req = 4'b0010; din = 16'h00A0;
    step();
    check_val("pre_rst_gnt", gnt, 4'b0010);
    async_reset();
    step();
    check_val("post_rst_gnt", gnt, 4'b0010);
    step();
    check_val("post_rst_dout", dout, 4'hA);
    wait_idle();

    // Single request from requester 2 with word 9
    req = 4'b0100; din = 16'h0900;
    step();
    check_val("single_gnt", gnt, 4'b0100);
    step();
    check_val("single_dout", dout, 4'h9);
    check_val("single_owner", owner, 2);
    req = '0;
    wait_idle();

    // Round-robin order starting from pointer 0
    @(negedge clk);
    async_reset();
    req = 4'b1111; din = 16'h4321;
    nload = 0;
    for (int i = 0; i < 60 && nload < 5; i++) begin
      step();
      if (load) begin
        seq_dout[nload] = dout; seq_cyc[nload] = cyc; nload++;
      end
    end
    check_val("rr_count", nload, 5);
    for (int i = 0; i < 5; i++) check_val("rr_dout", seq_dout[i], (i % 4) + 1);
    for (int i = 1; i < 5; i++) check_val("rr_spacing", seq_cyc[i] - seq_cyc[i-1], 3 + GAP);
    wait_idle();

    // Abort: requester 0 drops its request during GRANT.
    @(negedge clk);
    async_reset();
    din = 16'h000C;
    req = 4'b0001; step();
    req = 4'b0000; step();
    check_val("abort_load", load, 0);
    check_val("abort_dout", dout, 0);
    req = 4'b0011; step();
    check_val("abort_regrant", gnt, 4'b0001);
    wait_idle();

    // A clear that coincides with a load zeroes dout, while load and ack still pulse.
    req = 4'b0100; din = 16'h0F00;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("clr_dout", dout, 0);
    check_val("clr_load", load, 1);
    check_val("clr_ack", ack, 4'b0100);
    check_val("clr_owner", owner, 2);
    wait_idle();

    // Wrap: the pointer is now 3, so requester 3 wins first and requester 0 follows after the gap.
    req = 4'b1001; din = 16'h5006;
    nload = 0;
    for (int i = 0; i < 30 && nload < 2; i++) begin
      step();
      if (load) begin
        seq_dout[nload] = dout; nload++;
      end
    end
    check_val("wrap_count", nload, 2);
    check_val("wrap_first", seq_dout[0], 4'h5);
    check_val("wrap_second", seq_dout[1], 4'h6);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      din = 16'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
